// File: rtl/hd_pkg.sv
// Shared definitions for the disk syscall responder.
// Default geometry and timing, FSM state encodings and the latched op encoding.
package hd_pkg;

    localparam int unsigned HD_DATA_W  = 32;
    localparam int unsigned HD_ADDR_W  = 12;
    localparam int unsigned HD_WORDS   = 4096;
    localparam int unsigned HD_LATENCY = 4;

    localparam int unsigned HD_STATE_W = 2;

    localparam logic [HD_STATE_W-1:0] HD_IDLE   = 2'd0;
    localparam logic [HD_STATE_W-1:0] HD_ACCESS = 2'd1;
    localparam logic [HD_STATE_W-1:0] HD_DONE   = 2'd2;

    typedef enum logic {
        HD_OP_RD = 1'b0,
        HD_OP_WR = 1'b1
    } hd_op_e;

endpackage

// File: rtl/hd_storage.sv
// Disk storage array: single-port synchronous RAM with a one-cycle registered read.
// Ports: clk; we/addr/wdata write port; rdata = word at the address of the previous cycle.
// Out-of-range addresses read as zero and never write. Contents are not reset.
module hd_storage
    import hd_pkg::*;
#(
    parameter int unsigned DATA_W = HD_DATA_W,
    parameter int unsigned ADDR_W = HD_ADDR_W,
    parameter int unsigned WORDS  = HD_WORDS
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;
    logic              in_range;

    assign in_range = ({1'b0, addr} < (ADDR_W+1)'(WORDS));

    // Write and registered read share the single address port
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= in_range ? mem_q[addr] : '0;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hd_responder.sv
// Multi-cycle disk responder for the HD_TO_REG / REG_TO_HD syscalls of a single-cycle core.
// Ports: clk, rst (sync, active-high); sel_hd_r/sel_hd_w level requests with hd_addr/hd_wdata;
//        hd_rdata (valid with hd_done), hd_done/hd_err one-cycle pulses, hd_stall (combinational).
// Optional: define HD_ACCESS_COUNT_EN to add saturating hd_rd_count/hd_wr_count outputs.
module hd_responder
    import hd_pkg::*;
#(
    parameter int unsigned DATA_W  = HD_DATA_W,
    parameter int unsigned ADDR_W  = HD_ADDR_W,
    parameter int unsigned WORDS   = HD_WORDS,
    parameter int unsigned LATENCY = HD_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_hd_r,
    input  logic              sel_hd_w,
    input  logic [ADDR_W-1:0] hd_addr,
    input  logic [DATA_W-1:0] hd_wdata,
    output logic [DATA_W-1:0] hd_rdata,
    output logic              hd_done,
    output logic              hd_stall,
    output logic              hd_err
`ifdef HD_ACCESS_COUNT_EN
    ,
    output logic [15:0]       hd_rd_count,
    output logic [15:0]       hd_wr_count
`endif
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [HD_STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    hd_op_e                op_q, op_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  fault_q, fault_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  req;
    logic                  in_range;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_rdata;

    assign req      = sel_hd_r | sel_hd_w;
    assign in_range = ({1'b0, hd_addr} < (ADDR_W+1)'(WORDS));

    // In IDLE the RAM sees the live address so the read data is ready by the last ACCESS cycle
    assign mem_addr = (state_q == HD_IDLE) ? hd_addr : addr_q;

    // Next-state, request latch and access commit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            HD_IDLE: begin
                if (req) begin
                    // Both selects high degrades to a faulted read
                    op_d    = sel_hd_r ? HD_OP_RD : HD_OP_WR;
                    addr_d  = hd_addr;
                    wdata_d = hd_wdata;
                    fault_d = (sel_hd_r & sel_hd_w) | ~in_range;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = HD_ACCESS;
                end
            end
            HD_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = HD_DONE;
                    done_d  = 1'b1;
                    err_d   = fault_q;
                    if (op_q == HD_OP_RD) begin
                        rdata_d = mem_rdata;
                    end else begin
                        mem_we = ~fault_q & ~rst;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HD_DONE: begin
                // Same instruction is still presented; ignore it and release the core
                state_d = HD_IDLE;
            end
            default: begin
                state_d = HD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HD_IDLE;
            cnt_q   <= '0;
            op_q    <= HD_OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    hd_storage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS)
    ) u_storage (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign hd_rdata = rdata_q;
    assign hd_done  = done_q;
    assign hd_err   = err_q;
    assign hd_stall = ((state_q == HD_IDLE) && req) || (state_q == HD_ACCESS);

`ifdef HD_ACCESS_COUNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // Saturating counts of successful accesses, bumped during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if ((state_q == HD_DONE) && !fault_q) begin
            if ((op_q == HD_OP_RD) && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if ((op_q == HD_OP_WR) && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign hd_rd_count = rd_cnt_q;
    assign hd_wr_count = wr_cnt_q;
`endif

endmodule
